// File: rtl/poly_eval_seq_pkg.sv
// Shared constants for the sequential polynomial evaluator: FSM state
// encodings and the index-counter width rule.
package poly_eval_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Index counter must hold DEGREE-1 down to 0; never narrower than one bit.
  function automatic int idx_width(input int degree);
    return (degree < 1) ? 1 : $clog2(degree + 1);
  endfunction

endpackage

// File: rtl/poly_mac_sat.sv
// One Horner step: acc*x + c evaluated wide enough to never wrap, then
// clamped to OUT_W bits with a sticky saturation flag.
module poly_mac_sat #(
  parameter int IN_W   = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 17
) (
  input  logic [OUT_W-1:0]  acc,
  input  logic [IN_W-1:0]   x,
  input  logic [COEF_W-1:0] c,
  input  logic              sat_in,
  output logic [OUT_W-1:0]  acc_next,
  output logic              sat_out
);

  localparam int T_W = OUT_W + IN_W + 1;

  logic [T_W-1:0] w_t;

  assign w_t      = T_W'(acc) * T_W'(x) + T_W'(c);
  assign sat_out  = sat_in | (|w_t[T_W-1:OUT_W]);
  assign acc_next = sat_out ? '1 : w_t[OUT_W-1:0];

endmodule

// File: rtl/poly_eval_seq.sv
// Sequential Horner evaluator of an unsigned polynomial with start/valid
// handshake, run-time coefficients and sticky saturation of the result.
module poly_eval_seq
  import poly_eval_seq_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 17,
  parameter int DEGREE = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [IN_W-1:0]              x,
  input  logic [(DEGREE+1)*COEF_W-1:0] coef,
  output logic                         ready,
  output logic                         busy,
  output logic                         valid,
  output logic [OUT_W-1:0]             y,
  output logic                         ovf,
  output logic [1:0]                   dbg_state
);

  // Handshake: a request is taken on a rising edge where start=1 and ready=1;
  // valid is a single-cycle pulse marking y/ovf as a fresh result, and y/ovf
  // hold their value until the next pulse.

  localparam int IDX_W = idx_width(DEGREE);

  if (COEF_W > OUT_W) begin : g_bad_widths
    $error("poly_eval_seq: COEF_W must not exceed OUT_W");
  end

  logic [1:0]                   r_state;
  logic [IN_W-1:0]              r_x;
  logic [(DEGREE+1)*COEF_W-1:0] r_coef;
  logic [OUT_W-1:0]             r_acc;
  logic                         r_sat;
  logic [IDX_W-1:0]             r_idx;
  logic [OUT_W-1:0]             r_y;
  logic                         r_ovf;
  logic                         r_valid;

  logic                         w_accept;
  logic [COEF_W-1:0]            w_c;
  logic [OUT_W-1:0]             w_acc_next;
  logic                         w_sat_next;

  assign ready     = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign busy      = (r_state == ST_CALC);
  assign valid     = r_valid;
  assign y         = r_y;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;
  assign w_accept  = start && ready;

  always_comb begin
    w_c = '0;
    for (int i = 0; i <= DEGREE; i++) begin
      if (r_idx == IDX_W'(i)) w_c = r_coef[i*COEF_W +: COEF_W];
    end
  end

  poly_mac_sat #(
    .IN_W   (IN_W),
    .COEF_W (COEF_W),
    .OUT_W  (OUT_W)
  ) u_mac (
    .acc      (r_acc),
    .x        (r_x),
    .c        (w_c),
    .sat_in   (r_sat),
    .acc_next (w_acc_next),
    .sat_out  (w_sat_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_coef  <= '0;
      r_acc   <= '0;
      r_sat   <= 1'b0;
      r_idx   <= '0;
      r_y     <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= (r_state == ST_DONE);
      if (r_state == ST_DONE) begin
        r_y   <= r_acc;
        r_ovf <= r_sat;
      end
      // A start in DONE overlaps the publish of the previous result.
      if (w_accept) begin
        r_x     <= x;
        r_coef  <= coef;
        r_acc   <= OUT_W'(coef[DEGREE*COEF_W +: COEF_W]);
        r_sat   <= 1'b0;
        r_idx   <= (DEGREE > 0) ? IDX_W'(DEGREE - 1) : '0;
        r_state <= (DEGREE == 0) ? ST_DONE : ST_CALC;
      end else if (r_state == ST_CALC) begin
        r_acc <= w_acc_next;
        r_sat <= w_sat_next;
        if (r_idx == '0) r_state <= ST_DONE;
        else             r_idx   <= r_idx - 1'b1;
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_poly_eval_seq.sv
// Bench for poly_eval_seq: directed cases plus random traffic against a
// polynomial model, and two extra instances for degree 0 and degree 5.
module tb_poly_eval_seq;

  localparam int D = 3;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  x;
  logic [31:0] coef;
  logic        ready, busy, valid, ovf;
  logic [16:0] y;
  logic [1:0]  dbg_state;

  logic        s0, rdy0, bsy0, vld0, ovf0;
  logic [7:0]  x0, c0;
  logic [16:0] y0;
  logic [1:0]  st0;

  logic        s5, rdy5, bsy5, vld5, ovf5;
  logic [3:0]  x5;
  logic [47:0] c5;
  logic [16:0] y5;
  logic [1:0]  st5;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  bit cmp_en   = 0;

  logic [17:0] exp_q[$];
  longint      due_q[$];
  longint      edge_cnt = 0;
  int          m_left   = 0;
  logic [16:0] hold_y   = '0;
  logic        hold_ovf = 1'b0;

  poly_eval_seq dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .coef(coef),
    .ready(ready), .busy(busy), .valid(valid), .y(y), .ovf(ovf),
    .dbg_state(dbg_state)
  );

  poly_eval_seq #(.DEGREE(0)) dut0 (
    .clk(clk), .rst(rst), .start(s0), .x(x0), .coef(c0),
    .ready(rdy0), .busy(bsy0), .valid(vld0), .y(y0), .ovf(ovf0),
    .dbg_state(st0)
  );

  poly_eval_seq #(.IN_W(4), .DEGREE(5)) dut5 (
    .clk(clk), .rst(rst), .start(s5), .x(x5), .coef(c5),
    .ready(rdy5), .busy(bsy5), .valid(vld5), .y(y5), .ovf(ovf5),
    .dbg_state(st5)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Polynomial value via Horner steps; any partial result above the
  // output range pins the result to all-ones for the rest of the run.
  function automatic void poly_model(input int deg, input longint xv, input longint cv[8],
                                     input int ow, output longint yv, output bit sv);
    longint maxv = (longint'(1) << ow) - 1;
    longint a = cv[deg];
    sv = 1'b0;
    for (int k = deg - 1; k >= 0; k--) begin
      a = a * xv + cv[k];
      if (sv || a > maxv) begin
        sv = 1'b1;
        a  = maxv;
      end
    end
    yv = a;
  endfunction

  // ---------------- reference model of the main instance ----------------
  initial begin
    longint cv[8];
    longint my;
    bit     ms;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        due_q.delete();
        m_left   = 0;
        hold_y   = '0;
        hold_ovf = 1'b0;
      end else begin
        edge_cnt++;
        if (start && m_left == 0) begin
          for (int i = 0; i < 8; i++) cv[i] = (i <= D) ? longint'(coef[i*8 +: 8]) : 0;
          poly_model(D, longint'(x), cv, 17, my, ms);
          exp_q.push_back({ms, my[16:0]});
          due_q.push_back(edge_cnt + D + 1);
          m_left = D;
        end else if (m_left > 0) begin
          m_left--;
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  initial begin
    bit exp_v;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) n_valid++;
      if (!rst && cmp_en) begin
        exp_v = (due_q.size() > 0) && (due_q[0] == edge_cnt);
        chk("sb_valid", valid, exp_v);
        if (exp_v) begin
          {hold_ovf, hold_y} = exp_q.pop_front();
          void'(due_q.pop_front());
        end
        chk("sb_y", y, hold_y);
        chk("sb_ovf", ovf, hold_ovf);
        chk("sb_ready", ready, (m_left == 0));
        chk("sb_busy", busy, (m_left != 0));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run(input logic [7:0] xv, input logic [31:0] cv);
    @(negedge clk);
    start = 1'b1;
    x     = xv;
    coef  = cv;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    longint cv[8];
    longint my;
    bit     ms;
    int     lat;
    int     v0;

    rst = 1'b1; start = 1'b0; x = '0; coef = '0;
    s0 = 1'b0; x0 = '0; c0 = '0;
    s5 = 1'b0; x5 = '0; c5 = '0;

    repeat (2) @(negedge clk);
    chk("rst_y", y, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Pin the model against hand-computed values.
    cv = '{1, 2, 3, 4, 0, 0, 0, 0};
    poly_model(3, 2, cv, 17, my, ms);
    chk("model_t1", my, 49);
    cv = '{255, 255, 255, 255, 0, 0, 0, 0};
    poly_model(3, 255, cv, 17, my, ms);
    chk("model_t2_y", my, 64'h1FFFF);
    chk("model_t2_s", ms, 1);
    cv = '{7, 200, 200, 200, 0, 0, 0, 0};
    poly_model(3, 0, cv, 17, my, ms);
    chk("model_t3", my, 7);
    cv = '{1, 1, 1, 1, 1, 1, 0, 0};
    poly_model(5, 3, cv, 17, my, ms);
    chk("model_d5", my, 364);

    // Case 1: basic evaluation, ready low during CALC.
    run(8'd2, {8'd4, 8'd3, 8'd2, 8'd1});
    chk("t1_ready_calc", ready, 0);
    chk("t1_busy_calc", busy, 1);
    repeat (6) @(negedge clk);
    chk("t1_y", y, 49);
    chk("t1_ovf", ovf, 0);

    // Case 2: saturation, then a clean run clears it.
    run(8'd255, 32'hFFFF_FFFF);
    repeat (6) @(negedge clk);
    chk("t2_y", y, 17'h1FFFF);
    chk("t2_ovf", ovf, 1);
    run(8'd1, 32'h0101_0101);
    repeat (6) @(negedge clk);
    chk("t2b_y", y, 4);
    chk("t2b_ovf", ovf, 0);

    // Case 3: x=0, then start held high continuously.
    run(8'd0, {8'd200, 8'd200, 8'd200, 8'd7});
    repeat (6) @(negedge clk);
    chk("t3_y", y, 7);
    v0 = n_valid;
    @(negedge clk);
    start = 1'b1; x = 8'd3; coef = {8'd1, 8'd2, 8'd1, 8'd5};
    repeat (16) @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("t3_count", n_valid - v0, 4);

    // Case 4: start re-pulsed during CALC with a different x is ignored.
    run(8'd2, {8'd4, 8'd3, 8'd2, 8'd1});
    start = 1'b1; x = 8'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("t4_y", y, 49);

    // Case 5: asynchronous reset mid-CALC.
    run(8'd2, {8'd4, 8'd3, 8'd2, 8'd1});
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_y", y, 0);
    chk("t5_valid", valid, 0);
    chk("t5_ovf", ovf, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(8'd3, 32'h0101_0101);
    repeat (6) @(negedge clk);
    chk("t5_after", y, 40);

    // Case 6a: degree 0.
    @(negedge clk);
    s0 = 1'b1; x0 = 8'd5; c0 = 8'd9;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      s0 = 1'b0;
      if (vld0) begin
        lat = k;
        break;
      end
    end
    chk("d0_latency", lat, 2);
    cv = '{9, 0, 0, 0, 0, 0, 0, 0};
    poly_model(0, 5, cv, 17, my, ms);
    chk("d0_y", y0, my);
    chk("d0_ovf", ovf0, ms);

    // Case 6b: degree 5, 4-bit x.
    @(negedge clk);
    s5 = 1'b1; x5 = 4'd3; c5 = 48'h01_01_01_01_01_01;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      s5 = 1'b0;
      if (vld5) begin
        lat = k;
        break;
      end
    end
    chk("d5_latency", lat, 7);
    cv = '{1, 1, 1, 1, 1, 1, 0, 0};
    poly_model(5, 3, cv, 17, my, ms);
    chk("d5_y", y5, my);
    chk("d5_ovf", ovf5, 0);

    // Random traffic, including starts while busy.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 99) < 40);
      x     = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
      coef  = $urandom;
    end
    @(negedge clk);
    start = 1'b0;

    for (int k = 0; k < 50 && due_q.size() > 0; k++) @(negedge clk);
    chk("drain", due_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
